// File: rtl/mole_pkg.sv
// ============================================================================
// Module   : mole_pkg
// Brief    : Shared types and constants for the Whac-A-Mole scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        PICK = 2'd2,
        UP   = 2'd3
    } state_t;

    localparam int LFSR_W = 16;
    // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic int ms_cnt_width(input int up_ms, input int down_ms);
        int longest;
        longest = (up_ms > down_ms) ? up_ms : down_ms;
        return $clog2(longest) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mole_lfsr.sv
// ============================================================================
// Module   : mole_lfsr
// Brief    : Free-running 16-bit Galois LFSR used to seed mole placement.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // A non-zero seed can never reach the all-zero lock-up state
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/mole_scheduler.sv
// ============================================================================
// Module   : mole_scheduler
// Brief    : Round sequencer placing moles, timing phases, classifying hits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mole_scheduler
    import mole_pkg::*;
#(
    parameter int              CLKS_PER_MS  = 50000,
    parameter int              NUM_HOLES    = 18,
    parameter int              MAX_MOLES    = 3,
    parameter int              MOLE_UP_MS   = 1000,
    parameter int              MOLE_DOWN_MS = 500,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           level,
    input  logic [NUM_HOLES-1:0] sw,
    output logic [NUM_HOLES-1:0] mole_mask,
    output logic [NUM_HOLES-1:0] hit_mask,
    output logic [NUM_HOLES-1:0] miss_mask,
    output logic [NUM_HOLES-1:0] escape_mask,
    output logic                 busy
);

    localparam int PRE_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int MS_W   = ms_cnt_width(MOLE_UP_MS, MOLE_DOWN_MS);
    localparam int HOLE_W = $clog2(NUM_HOLES);
    localparam int CNT_W  = $clog2(MAX_MOLES + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [MS_W-1:0]   DOWN_LEN  = MS_W'(MOLE_DOWN_MS);
    localparam logic [CNT_W-1:0]  MOLES_C   = CNT_W'(MAX_MOLES);
    localparam logic [HOLE_W-1:0] LAST_HOLE = HOLE_W'(NUM_HOLES - 1);

    state_t                state_q, state_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [MS_W-1:0]       ms_q, ms_d;
    logic [MS_W-1:0]       up_ms_q, up_ms_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [HOLE_W-1:0]     cand_q, cand_d;
    logic                  first_q, first_d;
    logic [NUM_HOLES-1:0]  mole_q, mole_d;
    logic [NUM_HOLES-1:0]  hit_q, hit_d;
    logic [NUM_HOLES-1:0]  miss_q, miss_d;
    logic [NUM_HOLES-1:0]  esc_q, esc_d;
    logic                  busy_q;
    logic [NUM_HOLES-1:0]  sw_q;

    logic [LFSR_W-1:0]     lfsr;
    logic                  lfsr_unused_hi;
    logic [NUM_HOLES-1:0]  tog;
    logic [NUM_HOLES-1:0]  survivors;
    logic [HOLE_W-1:0]     rand_hole;
    logic [HOLE_W-1:0]     probe;
    logic [NUM_HOLES-1:0]  probe_oh;
    logic [MS_W-1:0]       phase_len;
    logic [MS_W-1:0]       up_shift;
    logic [MS_W-1:0]       up_len;
    logic                  ms_tick;
    logic                  expired;

    mole_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .lfsr_o (lfsr)
    );

    assign lfsr_unused_hi = ^lfsr[LFSR_W-1:8];

    assign tog       = sw ^ sw_q;
    assign survivors = mole_q & ~tog;
    assign rand_hole = HOLE_W'(lfsr[7:0] % 8'(NUM_HOLES));
    assign probe     = first_q ? rand_hole : cand_q;
    assign probe_oh  = NUM_HOLES'(1) << probe;

    assign up_shift  = MS_W'(MOLE_UP_MS >> level);
    assign up_len    = (up_shift == '0) ? MS_W'(1) : up_shift;
    assign phase_len = (state_q == UP) ? up_ms_q : DOWN_LEN;
    assign ms_tick   = (pre_q == PRE_LAST);
    assign expired   = ms_tick && (ms_q == phase_len - MS_W'(1));

    always_comb begin
        state_d = state_q;
        mole_d  = mole_q;
        hit_d   = '0;
        miss_d  = '0;
        esc_d   = '0;
        cnt_d   = '0;
        cand_d  = cand_q;
        first_d = 1'b1;
        up_ms_d = up_ms_q;

        case (state_q)
            IDLE: begin
                mole_d = '0;
                if (start) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                mole_d = '0;
                if (expired) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                cnt_d = cnt_q;
                if ((mole_q & probe_oh) == '0) begin
                    mole_d = mole_q | probe_oh;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == MOLES_C) begin
                        state_d = UP;
                        up_ms_d = up_len;
                    end
                end else begin
                    // Occupied: walk linearly to the next hole, wrapping
                    cand_d  = (probe == LAST_HOLE) ? '0 : probe + HOLE_W'(1);
                    first_d = 1'b0;
                end
            end
            UP: begin
                hit_d  = tog & mole_q;
                miss_d = tog & ~mole_q;
                mole_d = survivors;
                if (expired) begin
                    esc_d   = survivors;
                    mole_d  = '0;
                    state_d = DOWN;
                end else if (survivors == '0) begin
                    state_d = DOWN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop) begin
            state_d = IDLE;
            mole_d  = '0;
            hit_d   = '0;
            miss_d  = '0;
            esc_d   = '0;
        end
    end

    // Phase timer restarts on every state entry so phase lengths are exact
    always_comb begin
        pre_d = '0;
        ms_d  = '0;
        if ((state_d == state_q) && ((state_q == DOWN) || (state_q == UP))) begin
            if (ms_tick) begin
                ms_d = ms_q + MS_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
                ms_d  = ms_q;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            up_ms_q <= '0;
            cnt_q   <= '0;
            cand_q  <= '0;
            first_q <= 1'b1;
            mole_q  <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            esc_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            up_ms_q <= up_ms_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            first_q <= first_d;
            mole_q  <= mole_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            esc_q   <= esc_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Tracks switches through reset so release never looks like a toggle
    always_ff @(posedge CLOCK_50) begin
        sw_q <= sw;
    end

    assign mole_mask   = mole_q;
    assign hit_mask    = hit_q;
    assign miss_mask   = miss_q;
    assign escape_mask = esc_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire

// File: doc/mole_scheduler.md
# mole_scheduler

Parametrised mole generator and hit detector for the Whac-A-Mole game: places up to MAX_MOLES distinct moles across NUM_HOLES holes each round. Times the down/up phases in milliseconds, with the up phase shortened by a difficulty level. Classifies debounced switch toggles as hits or misses and reports moles that escape. Sits between the switch debouncers and the scoring/display logic in top_level, replacing the fixed single-window mole timing.

## Interface
- CLKS_PER_MS, 50000, clock cycles per millisecond tick
- NUM_HOLES, 18, number of holes/switches/LEDs (2..32)
- MAX_MOLES, 3, moles placed per round (1..NUM_HOLES/2)
- MOLE_UP_MS, 1000, base up-phase duration, ms
- MOLE_DOWN_MS, 500, down-phase duration, ms
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value
---
- CLOCK_50  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins play from IDLE
- stop  in  1  one-cycle pulse; returns to IDLE from any state
- level  in  2  difficulty; up time = MOLE_UP_MS >> level (min 1 ms)
- sw  in  NUM_HOLES  debounced switch levels
- mole_mask  out  NUM_HOLES  holes currently showing a mole
- hit_mask  out  NUM_HOLES  one-cycle: moles whacked this cycle
- miss_mask  out  NUM_HOLES  one-cycle: toggles on empty holes during UP
- escape_mask  out  NUM_HOLES  one-cycle: moles unhit at UP expiry
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, DOWN, PICK, UP.
- IDLE: mole_mask=0. start → DOWN. start ignored elsewhere.
- DOWN: mole_mask=0. Lasts MOLE_DOWN_MS ms → PICK.
- PICK: one probe per cycle. candidate = lfsr[7:0] mod NUM_HOLES on the first probe of each mole; if hole free, set it, count++, and take a fresh LFSR candidate next cycle; else next probe uses candidate+1 with wrap to 0. count==MAX_MOLES → UP. LFSR advances every cycle in all states.
- UP: lasts up_ms = max(1, MOLE_UP_MS >> level) ms; level sampled on entry to UP.
- Toggle detect: tog = sw ^ sw_q; sw_q <= sw every cycle, including during reset (no false toggle after reset).
- In UP, per bit: tog & mole_mask → hit_mask bit, mole bit cleared; tog & ~mole_mask → miss_mask bit. Multiple simultaneous toggles are all reported in the same cycle. Toggles outside UP are ignored.
- UP ends on timer expiry: escape_mask = remaining mole_mask (one cycle), mole_mask cleared → DOWN.
- UP also ends early when mole_mask becomes 0 after a hit → DOWN next cycle; escape_mask stays 0.
- Expiry in the same cycle as a hit: the hit is reported; the hit bit is excluded from escape_mask.
- stop: next edge → IDLE, mole_mask cleared, no escape reported.
- reset mid-operation: next edge → IDLE. All outputs 0. lfsr=LFSR_SEED. Timers 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; never reaches 0.

## Timing
- Reset values: mole_mask, hit_mask, miss_mask, escape_mask = 0; busy = 0; state IDLE.
- Prescaler and ms counter clear on every state entry. Phase lengths are exact:
  - DOWN = MOLE_DOWN_MS·CLKS_PER_MS cycles.
  - UP = up_ms·CLKS_PER_MS cycles.
- PICK: MAX_MOLES to MAX_MOLES·NUM_HOLES cycles.
- start at edge n → busy=1 at n+1.
- Toggle latency: sw change at edge n → hit/miss mask at n+1, mole bit cleared the same edge.
- All outputs registered. Masks are single-cycle pulses.

## Structure
- Package mole_pkg holds:
  - state enum (IDLE, DOWN, PICK, UP);
  - LFSR width and tap constant;
  - ms-counter width function ($clog2 of the maximum of MOLE_UP_MS and MOLE_DOWN_MS, plus 1).
- Sub-module mole_lfsr (16-bit Galois, seed parameter, always enabled).
- FSM, prescaler and mask logic live in mole_scheduler.

## Test plan
Common setup: CLKS_PER_MS=5, MOLE_UP_MS=5, MOLE_DOWN_MS=5, NUM_HOLES=18, MAX_MOLES=3, level=0.
- Assert reset with SW[3]=1, then release → all outputs 0; no miss_mask after release; busy=0.
- start pulse → busy next cycle; mole_mask=0 for exactly 25 cycles; then popcount(mole_mask)==3 within 54 cycles; bits distinct and <18.
- Mole up at hole k; toggle SW[k] → hit_mask=1<<k for one cycle; mole bit clears. Toggle an empty hole j → miss_mask=1<<j.
- No toggles → after exactly 25 UP cycles, escape_mask equals the prior mole_mask; mole_mask=0; DOWN lasts 25 cycles.
- Hit all 3 moles, two of them in the same cycle → hit_mask has 2 bits set; state goes to DOWN early; escape_mask never set. With level=3, UP lasts 5 cycles.
- stop pulse, and separately reset asserted, during UP → IDLE next edge; mole_mask=0; no escape; start relaunches the sequence.
